// File: rtl/ibram_write_controller_if.sv
// Stream-in / BRAM port A / read-side handshake bundle for the ping-pong input buffer writer.
// The controller sits on the slave modport; the producer/BRAM/read-controller side uses master.
interface ibram_write_controller_if #(
  parameter int STREAM_WIDTH = 64,
  parameter int WRITE_DEPTH  = 512
);
  localparam int AW = $clog2(WRITE_DEPTH);

  logic [STREAM_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;
  logic                    enaA;
  logic                    weA;
  logic [AW:0]             addrA_ping_pong;
  logic [STREAM_WIDTH-1:0] diA;
  logic [AW:0]             write_addr_pingpong_data;
  logic                    rd_release;
  logic                    rd_release_bank;
  logic [AW:0]             bank_len;
  logic                    bank_len_valid;
  logic                    release_err;

  modport slave (
    input  s_data, s_valid, s_last, rd_release, rd_release_bank,
    output s_ready, enaA, weA, addrA_ping_pong, diA,
           write_addr_pingpong_data, bank_len, bank_len_valid, release_err
  );

  modport master (
    output s_data, s_valid, s_last, rd_release, rd_release_bank,
    input  s_ready, enaA, weA, addrA_ping_pong, diA,
           write_addr_pingpong_data, bank_len, bank_len_valid, release_err
  );
endinterface

// File: rtl/ibram_write_controller.sv
// Writes an activation stream into a two-bank ping-pong BRAM, closing a bank on s_last or when
// full, and stalling the stream until the read side releases the next bank.
module ibram_write_controller #(
  parameter int STREAM_WIDTH = 64,
  parameter int WRITE_DEPTH  = 512
) (
  input logic                   clk,
  input logic                   rst_n,
  ibram_write_controller_if.slave bus
);
  localparam int AW = $clog2(WRITE_DEPTH);
  localparam logic [AW:0] LAST_PTR = (AW+1)'(WRITE_DEPTH - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] FILL      = 2'd1;
  localparam logic [1:0] WAIT_FREE = 2'd2;

  logic [1:0]  state;
  logic        pp_wr;
  logic [AW:0] wr_ptr;
  logic [1:0]  bank_full;
  logic [AW:0] wptr_pub;
  logic [AW:0] bank_len;
  logic        bank_len_valid;
  logic        release_err;

  logic        s_ready;
  logic        accept;
  logic        close;
  logic        rel_ok;
  logic [AW:0] wr_ptr_inc;
  logic [1:0]  bf_rel;
  logic [1:0]  bf_nxt;

  // Ready is a pure state decode so it is 0 from the first reset edge.
  assign s_ready    = (state == FILL);
  assign accept     = bus.s_valid & s_ready;
  assign close      = accept & (bus.s_last | (wr_ptr == LAST_PTR));
  assign rel_ok     = bus.rd_release & bank_full[bus.rd_release_bank];
  assign wr_ptr_inc = wr_ptr + 1'b1;

  // Release is applied against the pre-edge flags first, then a close re-sets its bank.
  always_comb begin
    bf_rel = bank_full;
    if (rel_ok) bf_rel[bus.rd_release_bank] = 1'b0;
    bf_nxt = bf_rel;
    if (close) bf_nxt[pp_wr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pp_wr          <= 1'b0;
      wr_ptr         <= '0;
      bank_full      <= 2'b00;
      wptr_pub       <= '0;
      bank_len       <= '0;
      bank_len_valid <= 1'b0;
      release_err    <= 1'b0;
    end else begin
      bank_len_valid <= 1'b0;
      bank_full      <= bf_nxt;
      if (bus.rd_release && !bank_full[bus.rd_release_bank]) release_err <= 1'b1;

      case (state)
        IDLE: state <= FILL;
        FILL: begin
          if (close) begin
            bank_len       <= wr_ptr_inc;
            bank_len_valid <= 1'b1;
            pp_wr          <= ~pp_wr;
            wr_ptr         <= '0;
            wptr_pub       <= {~pp_wr, {AW{1'b0}}};
            state          <= bf_rel[~pp_wr] ? WAIT_FREE : FILL;
          end else if (accept) begin
            wr_ptr   <= wr_ptr_inc;
            wptr_pub <= {pp_wr, wr_ptr_inc[AW-1:0]};
          end
        end
        WAIT_FREE: if (!bank_full[pp_wr]) state <= FILL;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready                  = s_ready;
  assign bus.enaA                     = accept;
  assign bus.weA                      = accept;
  assign bus.addrA_ping_pong          = {wr_ptr[AW-1:0], pp_wr};
  assign bus.diA                      = bus.s_data[STREAM_WIDTH-1:0];
  assign bus.write_addr_pingpong_data = wptr_pub;
  assign bus.bank_len                 = bank_len;
  assign bus.bank_len_valid           = bank_len_valid;
  assign bus.release_err              = release_err;
endmodule

// File: tb/tb_ibram_write_controller.sv
// Directed bench for ibram_write_controller with WRITE_DEPTH=8; BRAM writes checked via a scoreboard.
module tb_ibram_write_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ibram_write_controller_if #(.STREAM_WIDTH(64), .WRITE_DEPTH(8)) bus ();
  ibram_write_controller #(.STREAM_WIDTH(64), .WRITE_DEPTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [67:0] sb_q[$];  // {addrA, diA}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] addr);
    chk("send_ready", 64'(bus.s_ready), 64'd1);
    sb_q.push_back({addr, d});
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic release_bank(input logic b);
    bus.rd_release      = 1'b1;
    bus.rd_release_bank = b;
    tick();
    bus.rd_release = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.s_ready), 64'd1);
  endtask

  // Every BRAM write must match the oldest expected write; a write with nothing queued is a failure.
  always @(negedge clk) begin
    logic [67:0] e;
    if (bus.enaA === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_write", 64'(bus.enaA), 64'd0);
      else begin
        e = sb_q.pop_front();
        chk("addrA", 64'(bus.addrA_ping_pong), 64'(e[67:64]));
        chk("diA", bus.diA, e[63:0]);
        chk("weA", 64'(bus.weA), 64'd1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.rd_release = 1'b0; bus.rd_release_bank = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_enaA", 64'(bus.enaA), 64'd0);
    chk("rst_ptr", 64'(bus.write_addr_pingpong_data), 64'd0);
    chk("rst_len", 64'(bus.bank_len), 64'd0);
    chk("rst_lenv", 64'(bus.bank_len_valid), 64'd0);
    chk("rst_err", 64'(bus.release_err), 64'd0);
    rst_n = 1'b1;
    chk("idle_ready", 64'(bus.s_ready), 64'd0);
    wait_ready("idle_to_fill");

    // Basic 3-word tile; s_last without s_valid is ignored first.
    bus.s_last = 1'b1; tick(); bus.s_last = 1'b0;
    chk("last_novalid_ptr", 64'(bus.write_addr_pingpong_data), 64'h0);
    send(64'hA0, 1'b0, 4'h0); chk("ptr1", 64'(bus.write_addr_pingpong_data), 64'h1);
    send(64'hA1, 1'b0, 4'h2); chk("ptr2", 64'(bus.write_addr_pingpong_data), 64'h2);
    send(64'hA2, 1'b1, 4'h4);
    chk("len3", 64'(bus.bank_len), 64'd3);
    chk("len3_v", 64'(bus.bank_len_valid), 64'd1);
    chk("ptr_b1", 64'(bus.write_addr_pingpong_data), 64'h8);
    chk("nodead_ready", 64'(bus.s_ready), 64'd1);
    tick();
    chk("len_v_pulse", 64'(bus.bank_len_valid), 64'd0);

    // Full-bank close on bank 1, then both banks full -> backpressure.
    for (int i = 0; i < 8; i++) begin
      send(64'hB0 + 64'(i), 1'b0, 4'(i * 2 + 1));
      if (i < 7) chk("ptr_b1_fill", 64'(bus.write_addr_pingpong_data), 64'(8 + i + 1));
    end
    chk("len8", 64'(bus.bank_len), 64'd8);
    chk("len8_v", 64'(bus.bank_len_valid), 64'd1);
    chk("ptr_b0", 64'(bus.write_addr_pingpong_data), 64'h0);
    chk("full_ready", 64'(bus.s_ready), 64'd0);
    bus.s_valid = 1'b1; bus.s_data = 64'hDEAD; bus.s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", 64'(bus.s_ready), 64'd0);
    end
    release_bank(1'b0);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    chk("rel_ready_1cyc", 64'(bus.s_ready), 64'd0);
    tick();
    chk("rel_ready_2cyc", 64'(bus.s_ready), 64'd1);
    send(64'hC0, 1'b0, 4'h0);
    chk("resume_ptr", 64'(bus.write_addr_pingpong_data), 64'h1);

    // Close bank 1 in the same cycle bank 0 is released.
    release_bank(1'b1);
    send(64'hC1, 1'b1, 4'h2);
    chk("len2", 64'(bus.bank_len), 64'd2);
    chk("ptr_b1_again", 64'(bus.write_addr_pingpong_data), 64'h8);
    send(64'hD0, 1'b0, 4'h1);
    bus.rd_release = 1'b1; bus.rd_release_bank = 1'b0;
    send(64'hD1, 1'b1, 4'h3);
    bus.rd_release = 1'b0;
    chk("simul_ready", 64'(bus.s_ready), 64'd1);
    chk("simul_err", 64'(bus.release_err), 64'd0);
    chk("simul_len", 64'(bus.bank_len), 64'd2);
    chk("simul_lenv", 64'(bus.bank_len_valid), 64'd1);
    chk("simul_ptr", 64'(bus.write_addr_pingpong_data), 64'h0);
    tick();
    chk("simul_ready2", 64'(bus.s_ready), 64'd1);

    // Bad release of an empty bank 1: sticky error, flags untouched.
    release_bank(1'b1);
    chk("good_rel_err", 64'(bus.release_err), 64'd0);
    release_bank(1'b1);
    chk("bad_rel_err", 64'(bus.release_err), 64'd1);
    tick(); tick();
    chk("bad_rel_sticky", 64'(bus.release_err), 64'd1);
    send(64'hE0, 1'b1, 4'h0);
    chk("bad_rel_b1_free", 64'(bus.s_ready), 64'd1);
    send(64'hE1, 1'b1, 4'h1);
    chk("both_full_ready", 64'(bus.s_ready), 64'd0);
    chk("err_still", 64'(bus.release_err), 64'd1);

    // Reset mid-tile discards the partial fill.
    release_bank(1'b0);
    wait_ready("pre_reset_ready");
    for (int i = 0; i < 5; i++) send(64'hF0 + 64'(i), 1'b0, 4'(i * 2));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", 64'(bus.s_ready), 64'd0);
    chk("mid_rst_enaA", 64'(bus.enaA), 64'd0);
    chk("mid_rst_weA", 64'(bus.weA), 64'd0);
    chk("mid_rst_ptr", 64'(bus.write_addr_pingpong_data), 64'h0);
    chk("mid_rst_len", 64'(bus.bank_len), 64'd0);
    chk("mid_rst_lenv", 64'(bus.bank_len_valid), 64'd0);
    chk("mid_rst_err", 64'(bus.release_err), 64'd0);
    rst_n = 1'b1;
    wait_ready("post_rst_ready");
    send(64'h100, 1'b0, 4'h0);
    chk("post_rst_ptr", 64'(bus.write_addr_pingpong_data), 64'h1);
    send(64'h101, 1'b1, 4'h2);
    chk("post_rst_b1_free", 64'(bus.s_ready), 64'd1);
    chk("post_rst_len", 64'(bus.bank_len), 64'd2);

    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
